// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: streams the front framebuffer out of VRAM port A
// to the display pipeline through a credit-controlled pixel FIFO.
module fb_scanout_reader #(
  parameter int unsigned FB_BYTES   = 49152,
  parameter logic [17:0] BASE_ADDR  = 18'd49152,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        side,
  output logic [17:0] vram_addr_a,
  output logic        vram_rd_a,
  input  logic [7:0]  vram_q_a,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        BUSY,
  output logic        frame_miss
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [17:0] LAST = 18'(FB_BYTES - 1);
  localparam logic [PW+1:0] DEPTH = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_q;
  logic [17:0]   base_q;
  logic [17:0]   addr_q;
  logic [17:0]   raddr_q;
  logic          rd_q;
  logic          rd_last_q;
  logic          push_q;
  logic          push_last_q;
  logic          busy_q;
  logic          miss_q;
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   cnt_q;
  logic [PW:0]   cnt_d;
  logic [PW+1:0] used;
  logic          credit_ok;
  logic          pop;
  logic          empty;
  logic [8:0]    head;

  assign empty = (cnt_q == '0);
  assign pop   = !empty && pix_ready;
  // In-flight reads are charged; a same-cycle pop is not credited.
  assign used = {1'b0, cnt_q}
              + {{(PW+1){1'b0}}, rd_q}
              + {{(PW+1){1'b0}}, push_q};
  assign credit_ok = (used < DEPTH);
  assign cnt_d = cnt_q
               + {{PW{1'b0}}, push_q}
               - {{PW{1'b0}}, pop};

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      raddr_q     <= '0;
      rd_q        <= 1'b0;
      rd_last_q   <= 1'b0;
      push_q      <= 1'b0;
      push_last_q <= 1'b0;
      busy_q      <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      rd_q        <= 1'b0;
      rd_last_q   <= 1'b0;
      push_q      <= rd_q;
      push_last_q <= rd_last_q;
      miss_q      <= frame_start && busy_q;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            base_q  <= side ? BASE_ADDR : '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (credit_ok) begin
            rd_q      <= 1'b1;
            raddr_q   <= base_q + addr_q;
            rd_last_q <= (addr_q == LAST);
            addr_q    <= addr_q + 18'd1;
            if (addr_q == LAST) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty && !rd_q && !push_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_q) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // A read in flight across reset must not land in the FIFO.
  always_ff @(posedge CLK) begin
    if (push_q && !rst) mem_q[wptr_q] <= {push_last_q, vram_q_a};
  end

  assign head        = mem_q[rptr_q];
  assign pix_valid   = !empty;
  assign pix_data    = empty ? 8'h00 : head[7:0];
  assign pix_last    = !empty && head[8];
  assign vram_addr_a = raddr_q;
  assign vram_rd_a   = rd_q;
  assign BUSY        = busy_q;
  assign frame_miss  = miss_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb_fb_scanout_reader: directed bench for fb_scanout_reader with a
// 16-byte frame, base 16 and an 8-entry FIFO.
module tb_fb_scanout_reader;
  logic        CLK = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        side;
  logic [17:0] vram_addr_a;
  logic        vram_rd_a;
  logic [7:0]  vram_q_a = 8'h00;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        BUSY;
  logic        frame_miss;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n, first_valid, first_rd, last_pop, busy_fall;
  int miss_cnt, miss_cyc, issued, popped, max_inf;
  int i_mid, i_end;
  bit prev_busy;
  logic [17:0] alog[$];
  logic [7:0]  plog[$];
  bit          llog[$];

  always #5 CLK = ~CLK;

  fb_scanout_reader #(
    .FB_BYTES  (16),
    .BASE_ADDR (18'd16),
    .FIFO_DEPTH(8)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .frame_start(frame_start),
    .side       (side),
    .vram_addr_a(vram_addr_a),
    .vram_rd_a  (vram_rd_a),
    .vram_q_a   (vram_q_a),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .BUSY       (BUSY),
    .frame_miss (frame_miss)
  );

  function automatic logic [7:0] memf(input logic [17:0] a);
    logic [7:0] a8;
    a8 = a[7:0];
    return (a8 * 8'd37) ^ 8'hA5;
  endfunction

  // VRAM port A: one-cycle synchronous read
  always @(posedge CLK) begin
    if (vram_rd_a) vram_q_a <= memf(vram_addr_a);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk_cycle();
    @(negedge CLK);
    if (vram_rd_a) begin
      alog.push_back(vram_addr_a);
      issued++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (issued - popped > max_inf) max_inf = issued - popped;
    if (pix_valid && first_valid < 0) first_valid = cyc;
    if (pix_valid && pix_ready) begin
      plog.push_back(pix_data);
      llog.push_back(pix_last);
      popped++;
      last_pop = cyc;
    end
    if (frame_miss) begin
      miss_cnt++;
      miss_cyc = cyc;
    end
    if (prev_busy && !BUSY && busy_fall < 0) busy_fall = cyc;
    prev_busy = BUSY;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic new_frame();
    alog.delete();
    plog.delete();
    llog.delete();
    first_valid = -1;
    first_rd    = -1;
    last_pop    = -1;
    busy_fall   = -1;
    miss_cnt    = 0;
    miss_cyc    = -1;
    issued      = 0;
    popped      = 0;
    max_inf     = 0;
    prev_busy   = BUSY;
    n           = cyc;
  endtask

  task automatic fire(input logic sd);
    side        = sd;
    frame_start = 1'b1;
    new_frame();
    clk_cycle();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy_fall < 0 && k < 200) begin
      clk_cycle();
      k++;
    end
    chk({tag, " idle-timeout"}, 32'(busy_fall >= 0), 1);
  endtask

  task automatic chk_frame(input string tag, input logic [17:0] base);
    chk({tag, " nreads"}, alog.size(), 16);
    chk({tag, " npix"}, plog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < alog.size())
        chk($sformatf("%s addr%0d", tag, i), alog[i], base + i);
      if (i < plog.size()) begin
        chk($sformatf("%s pix%0d", tag, i), plog[i],
            memf(base + 18'(i)));
        chk($sformatf("%s last%0d", tag, i), llog[i], (i == 15));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    @(negedge CLK);
    chk(tag, {vram_addr_a, vram_rd_a, pix_data, pix_valid,
              pix_last, BUSY, frame_miss}, 0);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b1;
    side        = 1'b0;
    pix_ready   = 1'b0;
    @(posedge CLK);
    #1;
    cyc++;

    // 1: reset held with frame_start asserted
    repeat (5) chk_zero("t1 rst outs");
    rst         = 1'b0;
    frame_start = 1'b0;
    pix_ready   = 1'b1;
    repeat (2) clk_cycle();

    // 2: side=1 selects base 16
    fire(1'b1);
    wait_idle("t2");
    chk_frame("t2", 18'd16);
    chk("t2 first rd", first_rd, n + 2);
    chk("t2 first valid", first_valid, n + 4);
    chk("t2 last pop", last_pop, n + 19);
    chk("t2 busy fall", busy_fall, n + 21);
    chk("t2 miss", miss_cnt, 0);
    repeat (2) clk_cycle();

    // 3: side=0 selects base 0
    fire(1'b0);
    wait_idle("t3");
    chk_frame("t3", 18'd0);
    chk("t3 first valid", first_valid, n + 4);
    chk("t3 busy fall", busy_fall, n + 21);
    repeat (2) clk_cycle();

    // 4: 30-cycle consumer stall mid-frame
    fire(1'b1);
    repeat (5) clk_cycle();
    pix_ready = 1'b0;
    repeat (15) clk_cycle();
    i_mid = issued;
    repeat (15) clk_cycle();
    i_end = issued;
    chk("t4 reads stopped", i_end, i_mid);
    chk("t4 inflight at stall", issued - popped, 8);
    pix_ready = 1'b1;
    wait_idle("t4");
    chk_frame("t4", 18'd16);
    chk("t4 max inflight", max_inf, 8);
    repeat (2) clk_cycle();

    // 5: retrigger while busy, then side toggles
    fire(1'b1);
    repeat (5) clk_cycle();
    frame_start = 1'b1;
    clk_cycle();
    frame_start = 1'b0;
    side        = 1'b0;
    clk_cycle();
    wait_idle("t5");
    chk_frame("t5", 18'd16);
    chk("t5 miss count", miss_cnt, 1);
    chk("t5 miss cycle", miss_cyc, n + 7);
    repeat (2) clk_cycle();

    // 5b: frame_start on the DRAIN->IDLE cycle is missed
    fire(1'b1);
    repeat (19) clk_cycle();
    frame_start = 1'b1;
    clk_cycle();
    frame_start = 1'b0;
    repeat (4) clk_cycle();
    chk("t5b miss cycle", miss_cyc, n + 21);
    chk("t5b miss count", miss_cnt, 1);
    chk("t5b busy fall", busy_fall, n + 21);
    chk("t5b no restart reads", issued, 16);
    chk("t5b busy stays low", BUSY, 0);

    // 6: reset after pixel 7, then a clean frame from base 0
    fire(1'b1);
    for (int k = 0; k < 40 && popped < 7; k++) clk_cycle();
    chk("t6 reached pixel 7", popped, 7);
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    chk_zero("t6 outs after rst");
    repeat (2) clk_cycle();
    fire(1'b0);
    wait_idle("t6");
    chk_frame("t6", 18'd0);
    chk("t6 first valid", first_valid, n + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
